// File: rtl/mmio_ctrl.sv
// MMIO controller for the Riscv151 core: UART handshakes, cycle and retired-instruction counters.
// Load data is registered so it lines up with BRAM read latency at the writeback mux.
module mmio_ctrl #(
  parameter logic [3:0] ADDR_TAG  = 4'h8,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        rd_hit,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  typedef enum logic {TX_IDLE, TX_PEND} tx_state_e;

  tx_state_e            tx_state;
  logic [CNT_WIDTH-1:0] cycle_cnt, inst_cnt;
  logic                 sel, tx_pend, tx_wr, cnt_clr, rd_en;
  logic [7:0]           off;
  logic [31:0]          rd_val;
  logic                 unused_bits;

  assign sel     = (addr[31:28] == ADDR_TAG);
  assign off     = {addr[7:2], 2'b00};
  assign tx_pend = (tx_state == TX_PEND);
  assign tx_wr   = we && sel && (off == 8'h08);
  assign cnt_clr = we && sel && (off == 8'h18);
  assign rd_en   = re && sel;
  assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};

  // Pop happens in the load cycle itself; the byte is captured at the same edge.
  assign uart_dout_ready = rd_en && (off == 8'h04) && uart_dout_valid;

  always_comb begin
    rd_val = '0;
    case (off)
      8'h00:   rd_val = {30'b0, uart_dout_valid, !tx_pend};
      8'h04:   rd_val = {24'b0, uart_dout};
      8'h10:   rd_val = 32'(cycle_cnt);
      8'h14:   rd_val = 32'(inst_cnt);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rd_hit <= 1'b0;
    end else begin
      rd_hit <= rd_en;
      if (rd_en) rdata <= rd_val;
    end
  end

  // Writes arriving while a byte is pending (including the handshake cycle) are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state       <= TX_IDLE;
      uart_din       <= '0;
      uart_din_valid <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_wr) begin
          uart_din       <= wdata[7:0];
          uart_din_valid <= 1'b1;
          tx_state       <= TX_PEND;
        end
        TX_PEND: if (uart_din_ready) begin
          uart_din_valid <= 1'b0;
          tx_state       <= TX_IDLE;
        end
        default: begin
          uart_din_valid <= 1'b0;
          tx_state       <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (inst_retire) inst_cnt <= inst_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller for the Riscv151 core: it connects the on-chip UART, a cycle counter and a retired-instruction counter to the CPU load/store path.
- It decodes execute-stage loads and stores whose address has top nibble ADDR_TAG.
- It sequences the UART ready/valid handshakes.
- It returns load data registered one cycle later, so it aligns with BRAM read latency for the writeback-stage mux.

Parameters:
ADDR_TAG, 4'h8, value of addr[31:28] that selects MMIO space
CNT_WIDTH, 32, width of the cycle and instruction counters (read data zero-extended to 32)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
addr  input  32  execute-stage ALU address
wdata  input  32  execute-stage store data (rs2, forwarded)
we  input  1  store in execute stage (any width)
re  input  1  load in execute stage
inst_retire  input  1  one instruction completes writeback this cycle
rdata  output  32  registered MMIO load data, valid in the cycle after re
rd_hit  output  1  registered: previous-cycle load targeted MMIO space (wb mux select)
uart_din  output  8  byte to UART transmitter
uart_din_valid  output  1  TX byte valid
uart_din_ready  input  1  UART transmitter can accept a byte
uart_dout  input  8  received byte
uart_dout_valid  input  1  received byte available
uart_dout_ready  output  1  pop received byte

Behaviour:
- Select: sel = (addr[31:28]==ADDR_TAG). Offset = addr[7:0]. addr[1:0] are ignored and accesses are word-granular.
- Register map:
  - 0x00, read-only: {30'b0, rx_valid, tx_ready}, where rx_valid = uart_dout_valid and tx_ready = !tx_pend.
  - 0x04, read-only: {24'b0, uart_dout}.
  - 0x08, write-only: TX byte = wdata[7:0].
  - 0x10, read-only: cycle count.
  - 0x14, read-only: instruction count.
  - 0x18, write-only: any write clears both counters.
  - Unmapped offsets read 0. Writes to unmapped or read-only offsets are ignored.
- Reset (async): rdata=0, rd_hit=0, tx_pend=0, uart_din=0, uart_din_valid=0, cycle_cnt=0, inst_cnt=0.
- Load latency:
  - On the clock edge ending a cycle with re&&sel, rdata captures the mapped value and rd_hit<=1.
  - Otherwise rd_hit<=0 and rdata holds its value.
- RX pop: uart_dout_ready = re && sel && offset==0x04 && uart_dout_valid. It is combinational and high during the load cycle only.
  - A read of 0x04 with no valid byte returns the current uart_dout and pops nothing.
- TX state machine, two states:
  - IDLE (tx_pend=0): a store with sel && offset==0x08 latches uart_din<=wdata[7:0] and moves to PEND.
  - PEND (tx_pend=1): uart_din_valid=1 and uart_din is held stable. A cycle with uart_din_ready=1 completes the handshake, and the state returns to IDLE at that edge.
  - A TX write while in PEND is dropped; uart_din is unchanged. Software must poll tx_ready.
  - A write in the same cycle the handshake completes is also dropped, because the status read earlier showed not-ready.
- uart_din_valid equals tx_pend and is registered. The first valid cycle is the cycle after the store.
- Counters:
  - cycle_cnt increments every cycle. inst_cnt increments when inst_retire=1.
  - Both wrap from all-ones to 0.
  - A counter-clear store sets both counters to 0 at that edge. Clear has priority over increment in the same cycle.
  - A read captures the pre-edge count value.
- Only one of we/re is asserted per cycle. If both are asserted, the store takes effect and the read data is still captured.
- Reset mid-transfer: tx_pend is cleared and the byte is abandoned. The UART is reset by the same rst.

Test Plan:
- Reset then idle 10 cycles: load 0x80000010 -> rdata=10 (+/-0 per the capture rule; checked against the bench cycle model), rd_hit=1 for exactly one cycle. Load 0x80000000 -> rdata=32'h1.
- Store 0x80000008 wdata=0x41 with uart_din_ready=0 for 3 cycles: uart_din_valid=1, uart_din=0x41 held. Raise ready 1 cycle -> valid drops next cycle. A second store during PEND (0x42) is dropped; uart_din stays 0x41.
- uart_dout_valid=1, uart_dout=0x5A: load 0x80000000 -> 32'h3. Load 0x80000004 -> uart_dout_ready pulses 1 cycle, rdata=0x5A.
- Pulse inst_retire 7 times, then store 0x80000018 in a cycle with inst_retire=1: the next load of 0x14 -> 0 and of 0x10 -> 1 (clear wins over increment).
- Force cycle_cnt to 32'hFFFFFFFF (preload/hierarchical): the next cycle reads 0 (wrap).
- Assert rst asynchronously mid-PEND: uart_din_valid drops immediately, all counters read 0. Load 0x80000050 (unmapped) -> 0.
